multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multicycle control FSM that sequences the RV32I datapath around the instruction decoder.
- Latches the fetched instruction and consumes the decoder's opcode/funct3/rd fields.
- Drives PC, IR, register-file, ALU-mux and data-memory strobes for one instruction at a time.
- Detects illegal opcodes, SYSTEM instructions and memory-handshake timeouts, then parks in a trap state.

Parameters:
TIMEOUT_CYCLES, 0, max cycles mem_req_o may stay unacknowledged before a bus-error trap; 0 disables the check
TMO_W, 8, width of the timeout counter; TIMEOUT_CYCLES must be < 2**TMO_W

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-high
opcode_i  in  7  decoder opcode of the latched IR
funct3_i  in  3  decoder funct3
rd_addr_i  in  5  decoder rd
branch_taken_i  in  1  branch comparator result, valid in EXEC
mem_ready_i  in  1  memory acknowledges the current mem_req_o
mem_req_o  out  1  memory request (FETCH, MEM)
mem_we_o  out  1  store when 1
addr_sel_o  out  1  0 = PC, 1 = ALU result as memory address
ir_we_o  out  1  latch instruction register
pc_we_o  out  1  update PC
pc_src_o  out  2  0 PC+4, 1 PC+imm, 2 ALU&~1
alu_a_sel_o  out  1  0 rs1, 1 PC
alu_b_sel_o  out  1  0 rs2, 1 imm
reg_we_o  out  1  register-file write
wb_sel_o  out  2  0 ALU, 1 MEM, 2 PC+4, 3 IMM
instr_done_o  out  1  one-cycle pulse at retirement
trap_o  out  1  controller halted in TRAP
trap_cause_o  out  2  0 none, 1 illegal, 2 mem timeout, 3 ECALL/EBREAK
state_o  out  3  current state, for debug

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- All outputs are combinational from state and inputs. Every strobe is forced to 0 while rst_i=1.
- Reset: state=FETCH, trap_cause_o=0, timeout counter=0. First cycle after reset asserts mem_req_o=1.
- FETCH: mem_req_o=1, addr_sel_o=0, mem_we_o=0. When mem_ready_i=1: ir_we_o=1 in the same cycle, next state DECODE. Otherwise stay.
- DECODE:
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 0110111, 0010111, 0001111.
  - 1100111 is legal only with funct3=000.
  - 1110011 -> TRAP, cause 3. Any other opcode -> TRAP, cause 1.
  - Legal -> EXEC.
- EXEC: alu_a_sel_o=1 for AUIPC, JAL and branch, else 0. alu_b_sel_o=0 for R-type and branch, else 1.
  - Branch: pc_we_o=1, pc_src_o = branch_taken_i ? 1 : 0, instr_done_o=1, next FETCH.
  - Load/store: next MEM.
  - All others: next WB.
- MEM: mem_req_o=1, addr_sel_o=1, mem_we_o=1 for store. Hold until mem_ready_i.
  - Store acknowledged: pc_we_o=1, pc_src_o=0, instr_done_o=1, next FETCH.
  - Load acknowledged: next WB.
- WB:
  - reg_we_o=1 unless rd_addr_i=0 or FENCE.
  - wb_sel_o: load=1, JAL/JALR=2, LUI=3, else 0.
  - pc_we_o=1. pc_src_o: JAL=1, JALR=2, else 0.
  - instr_done_o=1, next FETCH.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter clears on entry to FETCH/MEM and on each mem_ready_i.
  - It increments on each cycle with mem_req_o=1 and mem_ready_i=0.
  - When it reaches TIMEOUT_CYCLES with no ack: TRAP, cause 2.
  - mem_ready_i arriving in the same cycle the count is reached wins; no trap.
- TRAP: all strobes 0, trap_o=1, cause held. Only rst_i exits.
- mem_ready_i outside FETCH/MEM is ignored.
- Reset mid-handshake (MEM waiting): next cycle is FETCH. No write strobe is issued during or after the reset cycle.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt_o[31:0] and instret_cnt_o[31:0].
  - cycle_cnt_o increments every cycle not in TRAP.
  - instret_cnt_o increments on instr_done_o.
  - Both reset to 0 and wrap modulo 2**32.
- Undefined: ports and counters absent; FSM behaviour identical.

Test Plan:
- ADDI x1 (0x00500093), mem_ready_i=1 immediately -> states 0,1,2,4,0. reg_we_o=1, wb_sel_o=0 and pc_we_o=1 (pc_src_o=0) in WB. instr_done_o pulses once, 4 cycles per instruction.
- BEQ with branch_taken_i=1, then again with 0 -> states 0,1,2,0. pc_src_o=1 then 0 in EXEC. reg_we_o never asserted.
- LW with mem_ready_i delayed 3 cycles in MEM -> mem_req_o=1 and addr_sel_o=1 for 4 cycles, then WB with wb_sel_o=1. Retires after 8 cycles total.
- Opcode 0x7F, then ECALL 0x00000073 -> TRAP with cause 1, then after reset cause 3. trap_o stays 1 with no strobes for 20 cycles until rst_i.
- TIMEOUT_CYCLES=4, mem_ready_i=0 in FETCH -> TRAP, cause 2, after exactly 4 request cycles. Repeating with ack on the 4th cycle -> no trap.
- rst_i pulsed while waiting in MEM on an SW -> mem_we_o=0 in the reset cycle, FETCH next cycle. With CTRL_PERF_CNT_EN, both counters read 0 after reset.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback and traps.
// Optional macro CTRL_PERF_CNT_EN adds cycle_cnt_o / instret_cnt_o performance counters.
//
//  state  | meaning
//  FETCH  | request instruction at PC, latch IR on ack
//  DECODE | classify opcode, trap on illegal or SYSTEM
//  EXEC   | drive ALU operand selects, resolve branches
//  MEM    | load/store data access at ALU address
//  WB     | register write-back and PC update
//  TRAP   | halted with cause held until reset
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned TMO_W          = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        branch_taken_i,
    input  logic        mem_ready_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        addr_sel_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic [1:0]  pc_src_o,
    output logic        alu_a_sel_o,
    output logic        alu_b_sel_o,
    output logic        reg_we_o,
    output logic [1:0]  wb_sel_o,
    output logic        instr_done_o,
    output logic        trap_o,
    output logic [1:0]  trap_cause_o,
`ifdef CTRL_PERF_CNT_EN
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instret_cnt_o,
`endif
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam bit             TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TMO_W-1:0] TMO_LAST =
        TMO_W'((TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1));

    state_e             state_q, state_d;
    logic [1:0]         cause_q, cause_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    logic is_op, is_load, is_store, is_branch, is_jal, is_jalr;
    logic is_lui, is_auipc, is_fence, is_system, is_legal;

    always_comb begin
        is_op     = (opcode_i == OPC_OP);
        is_load   = (opcode_i == OPC_LOAD);
        is_store  = (opcode_i == OPC_STORE);
        is_branch = (opcode_i == OPC_BRANCH);
        is_jal    = (opcode_i == OPC_JAL);
        is_jalr   = (opcode_i == OPC_JALR) && (funct3_i == 3'b000);
        is_lui    = (opcode_i == OPC_LUI);
        is_auipc  = (opcode_i == OPC_AUIPC);
        is_fence  = (opcode_i == OPC_FENCE);
        is_system = (opcode_i == OPC_SYSTEM);
        is_legal  = is_op || (opcode_i == OPC_OP_IMM) || is_load || is_store ||
                    is_branch || is_jal || is_jalr || is_lui || is_auipc || is_fence;
    end

    // Counter runs only while a request waits; any other cycle leaves it cleared.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        tmo_d   = '0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready_i) begin
                    state_d = S_DECODE;
                end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    cause_d = is_system ? 2'd3 : 2'd1;
                end
            end
            S_EXEC: begin
                if (is_branch)                 state_d = S_FETCH;
                else if (is_load || is_store)  state_d = S_MEM;
                else                           state_d = S_WB;
            end
            S_MEM: begin
                if (mem_ready_i) begin
                    state_d = is_store ? S_FETCH : S_WB;
                end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        addr_sel_o   = 1'b0;
        ir_we_o      = 1'b0;
        pc_we_o      = 1'b0;
        pc_src_o     = 2'd0;
        alu_a_sel_o  = 1'b0;
        alu_b_sel_o  = 1'b0;
        reg_we_o     = 1'b0;
        wb_sel_o     = 2'd0;
        instr_done_o = 1'b0;
        trap_o       = 1'b0;
        if (!rst_i) begin
            case (state_q)
                S_FETCH: begin
                    mem_req_o = 1'b1;
                    ir_we_o   = mem_ready_i;
                end
                S_EXEC: begin
                    alu_a_sel_o = is_auipc || is_jal || is_branch;
                    alu_b_sel_o = !(is_op || is_branch);
                    if (is_branch) begin
                        pc_we_o      = 1'b1;
                        pc_src_o     = branch_taken_i ? 2'd1 : 2'd0;
                        instr_done_o = 1'b1;
                    end
                end
                S_MEM: begin
                    mem_req_o  = 1'b1;
                    addr_sel_o = 1'b1;
                    mem_we_o   = is_store;
                    if (mem_ready_i && is_store) begin
                        pc_we_o      = 1'b1;
                        instr_done_o = 1'b1;
                    end
                end
                S_WB: begin
                    reg_we_o     = (rd_addr_i != 5'd0) && !is_fence;
                    pc_we_o      = 1'b1;
                    instr_done_o = 1'b1;
                    if (is_load)                 wb_sel_o = 2'd1;
                    else if (is_jal || is_jalr)  wb_sel_o = 2'd2;
                    else if (is_lui)             wb_sel_o = 2'd3;
                    if (is_jal)                  pc_src_o = 2'd1;
                    else if (is_jalr)            pc_src_o = 2'd2;
                end
                S_TRAP:  trap_o = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = (state_q != S_TRAP) ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
        instret_cnt_d = instr_done_o ? instret_cnt_q + 32'd1 : instret_cnt_q;
    end

    assign cycle_cnt_o   = cycle_cnt_q;
    assign instret_cnt_o = instret_cnt_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_FETCH;
            cause_q       <= 2'd0;
            tmo_q         <= '0;
`ifdef CTRL_PERF_CNT_EN
            cycle_cnt_q   <= 32'd0;
            instret_cnt_q <= 32'd0;
`endif
        end else begin
            state_q       <= state_d;
            cause_q       <= cause_d;
            tmo_q         <= tmo_d;
`ifdef CTRL_PERF_CNT_EN
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
`endif
        end
    end

    assign state_o      = state_q;
    assign trap_cause_o = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl (timeout check enabled at 4 cycles).
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_FENCE = 7'b0001111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd_addr;
    logic        taken;
    logic        ready;
    logic        mem_req, mem_we, addr_sel, ir_we, pc_we, alu_a, alu_b, reg_we, done, trap;
    logic [1:0]  pc_src, wb_sel, cause;
    logic [2:0]  state;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT_CYCLES(4), .TMO_W(8)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .opcode_i       (opcode),
        .funct3_i       (funct3),
        .rd_addr_i      (rd_addr),
        .branch_taken_i (taken),
        .mem_ready_i    (ready),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .addr_sel_o     (addr_sel),
        .ir_we_o        (ir_we),
        .pc_we_o        (pc_we),
        .pc_src_o       (pc_src),
        .alu_a_sel_o    (alu_a),
        .alu_b_sel_o    (alu_b),
        .reg_we_o       (reg_we),
        .wb_sel_o       (wb_sel),
        .instr_done_o   (done),
        .trap_o         (trap),
        .trap_cause_o   (cause),
`ifdef CTRL_PERF_CNT_EN
        .cycle_cnt_o    (cycle_cnt),
        .instret_cnt_o  (instret_cnt),
`endif
        .state_o        (state)
    );

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        tk;
        logic        rdy;
        logic [2:0]  st;
        logic [15:0] ex;
    } vec_t;

    vec_t vq[$];

    // {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_a, alu_b, reg_we, wb_sel, done, trap, cause}
    function automatic logic [15:0] e(input int mreq, input int mwe, input int asel, input int irwe,
                                      input int pcwe, input int pcsrc, input int aa, input int ab,
                                      input int rwe, input int wb, input int dn, input int tr,
                                      input int cs);
        return {1'(mreq), 1'(mwe), 1'(asel), 1'(irwe), 1'(pcwe), 2'(pcsrc), 1'(aa), 1'(ab),
                1'(rwe), 2'(wb), 1'(dn), 1'(tr), 2'(cs)};
    endfunction

    function automatic logic [15:0] outs();
        return {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_a, alu_b,
                reg_we, wb_sel, done, trap, cause};
    endfunction

    task automatic add(input int r, input logic [6:0] op, input int f3, input int rd,
                       input int tk, input int rdy, input int st, input logic [15:0] ex);
        vec_t v;
        v.rst = 1'(r);  v.op = op;  v.f3 = 3'(f3);  v.rd = 5'(rd);
        v.tk  = 1'(tk); v.rdy = 1'(rdy); v.st = 3'(st); v.ex = ex;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drv(input int r, input logic [6:0] op, input int f3, input int rd,
                       input int tk, input int rdy);
        rst = 1'(r); opcode = op; funct3 = 3'(f3); rd_addr = 5'(rd);
        taken = 1'(tk); ready = 1'(rdy);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drv(1, OP_I, 0, 1, 0, 0);
        tick();
        drv(0, OP_I, 0, 1, 0, 0);
    endtask

    logic [15:0] F_ACK, EX_IMM, EX_ZERO, WB_NOREG, MEM_LD;

    initial begin
        F_ACK    = e(1,0,0,1,0,0,0,0,0,0,0,0,0);
        EX_IMM   = e(0,0,0,0,0,0,0,1,0,0,0,0,0);
        EX_ZERO  = 16'h0000;
        WB_NOREG = e(0,0,0,0,1,0,0,0,0,0,1,0,0);
        MEM_LD   = e(1,0,1,0,0,0,0,0,0,0,0,0,0);

        add(1, OP_I, 0, 1, 0, 0, 0, 16'h0000);
        // ADDI x1
        add(0, OP_I, 0, 1, 0, 1, 0, F_ACK);
        add(0, OP_I, 0, 1, 0, 1, 1, 16'h0000);
        add(0, OP_I, 0, 1, 0, 1, 2, EX_IMM);
        add(0, OP_I, 0, 1, 0, 1, 4, e(0,0,0,0,1,0,0,0,1,0,1,0,0));
        // BEQ taken then not taken
        add(0, OP_BR, 0, 0, 1, 1, 0, F_ACK);
        add(0, OP_BR, 0, 0, 1, 1, 1, 16'h0000);
        add(0, OP_BR, 0, 0, 1, 1, 2, e(0,0,0,0,1,1,1,0,0,0,1,0,0));
        add(0, OP_BR, 0, 0, 0, 1, 0, F_ACK);
        add(0, OP_BR, 0, 0, 0, 1, 1, 16'h0000);
        add(0, OP_BR, 0, 0, 0, 1, 2, e(0,0,0,0,1,0,1,0,0,0,1,0,0));
        // LW x2 with 3 wait cycles; ack lands on the last allowed timeout cycle
        add(0, OP_LD, 2, 2, 0, 1, 0, F_ACK);
        add(0, OP_LD, 2, 2, 0, 1, 1, 16'h0000);
        add(0, OP_LD, 2, 2, 0, 1, 2, EX_IMM);
        add(0, OP_LD, 2, 2, 0, 0, 3, MEM_LD);
        add(0, OP_LD, 2, 2, 0, 0, 3, MEM_LD);
        add(0, OP_LD, 2, 2, 0, 0, 3, MEM_LD);
        add(0, OP_LD, 2, 2, 0, 1, 3, MEM_LD);
        add(0, OP_LD, 2, 2, 0, 1, 4, e(0,0,0,0,1,0,0,0,1,1,1,0,0));
        // JAL x1
        add(0, OP_JAL, 0, 1, 0, 1, 0, F_ACK);
        add(0, OP_JAL, 0, 1, 0, 1, 1, 16'h0000);
        add(0, OP_JAL, 0, 1, 0, 1, 2, e(0,0,0,0,0,0,1,1,0,0,0,0,0));
        add(0, OP_JAL, 0, 1, 0, 1, 4, e(0,0,0,0,1,1,0,0,1,2,1,0,0));
        // JALR x1
        add(0, OP_JALR, 0, 1, 0, 1, 0, F_ACK);
        add(0, OP_JALR, 0, 1, 0, 1, 1, 16'h0000);
        add(0, OP_JALR, 0, 1, 0, 1, 2, EX_IMM);
        add(0, OP_JALR, 0, 1, 0, 1, 4, e(0,0,0,0,1,2,0,0,1,2,1,0,0));
        // LUI x3
        add(0, OP_LUI, 0, 3, 0, 1, 0, F_ACK);
        add(0, OP_LUI, 0, 3, 0, 1, 1, 16'h0000);
        add(0, OP_LUI, 0, 3, 0, 1, 2, EX_IMM);
        add(0, OP_LUI, 0, 3, 0, 1, 4, e(0,0,0,0,1,0,0,0,1,3,1,0,0));
        // FENCE with nonzero rd field: no register write
        add(0, OP_FENCE, 0, 5, 0, 1, 0, F_ACK);
        add(0, OP_FENCE, 0, 5, 0, 1, 1, 16'h0000);
        add(0, OP_FENCE, 0, 5, 0, 1, 2, EX_IMM);
        add(0, OP_FENCE, 0, 5, 0, 1, 4, WB_NOREG);
        // ADD x0: R-type operands, write to x0 suppressed
        add(0, OP_R, 0, 0, 0, 1, 0, F_ACK);
        add(0, OP_R, 0, 0, 0, 1, 1, 16'h0000);
        add(0, OP_R, 0, 0, 0, 1, 2, EX_ZERO);
        add(0, OP_R, 0, 0, 0, 1, 4, WB_NOREG);
        // SW with one wait cycle
        add(0, OP_ST, 2, 0, 0, 1, 0, F_ACK);
        add(0, OP_ST, 2, 0, 0, 1, 1, 16'h0000);
        add(0, OP_ST, 2, 0, 0, 1, 2, EX_IMM);
        add(0, OP_ST, 2, 0, 0, 0, 3, e(1,1,1,0,0,0,0,0,0,0,0,0,0));
        add(0, OP_ST, 2, 0, 0, 1, 3, e(1,1,1,0,1,0,0,0,0,0,1,0,0));
        // JALR with funct3 != 0 is illegal
        add(0, OP_JALR, 1, 1, 0, 1, 0, F_ACK);
        add(0, OP_JALR, 1, 1, 0, 1, 1, 16'h0000);
        add(0, OP_JALR, 1, 1, 1, 1, 7, e(0,0,0,0,0,0,0,0,0,0,0,1,1));

        drv(1, OP_I, 0, 1, 0, 0);
        tick();

        for (int i = 0; i < vq.size(); i++) begin
            drv(int'(vq[i].rst), vq[i].op, int'(vq[i].f3), int'(vq[i].rd),
                int'(vq[i].tk), int'(vq[i].rdy));
            @(negedge clk);
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vq[i].st));
            chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vq[i].ex));
            tick();
        end

        // TRAP is sticky with no strobes regardless of inputs
        for (int k = 0; k < 20; k++) begin
            drv(0, OP_JALR, 1, 1, k % 2, k % 2);
            @(negedge clk);
            chk($sformatf("trap_hold%0d", k), {13'd0, state, outs()},
                {13'd0, 3'd7, e(0,0,0,0,0,0,0,0,0,0,0,1,1)});
            tick();
        end
        drv(1, OP_JALR, 1, 1, 1, 1);
        @(negedge clk);
        chk("trap_rst_cycle_outs", 32'(trap), 32'd0);
        tick();
        drv(0, OP_I, 0, 1, 0, 0);
        @(negedge clk);
        chk("post_rst_state", 32'(state), 32'd0);
        chk("post_rst_cause", 32'(cause), 32'd0);
        chk("post_rst_req", 32'(mem_req), 32'd1);
        tick();

        // Unknown opcode 0x7F then ECALL
        do_reset();
        drv(0, OP_BAD, 0, 0, 0, 1);
        tick(); tick();
        #1;
        chk("bad_opc_trap", {28'd0, trap, state}, {28'd0, 1'b1, 3'd7});
        chk("bad_opc_cause", 32'(cause), 32'd1);
        do_reset();
        drv(0, OP_SYS, 0, 0, 0, 1);
        tick(); tick();
        chk("ecall_trap", {28'd0, trap, state}, {28'd0, 1'b1, 3'd7});
        chk("ecall_cause", 32'(cause), 32'd3);

        // Fetch timeout: exactly 4 unacknowledged request cycles
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("tmo_wait%0d", k), {28'd0, mem_req, state}, {28'd0, 1'b1, 3'd0});
            tick();
        end
        @(negedge clk);
        chk("tmo_trap", {28'd0, trap, state}, {28'd0, 1'b1, 3'd7});
        chk("tmo_cause", 32'(cause), 32'd2);

        // Ack in the 4th request cycle wins over the timeout
        do_reset();
        tick(); tick(); tick();
        drv(0, OP_I, 0, 1, 0, 1);
        tick();
        @(negedge clk);
        chk("tmo_ack_wins", {28'd0, trap, state}, {28'd0, 1'b0, 3'd1});
        tick();

        // Reset while SW waits in MEM
        do_reset();
        drv(0, OP_ST, 2, 0, 0, 1);
        tick(); tick(); tick();
        drv(0, OP_ST, 2, 0, 0, 0);
        @(negedge clk);
        chk("sw_mem_we", {28'd0, mem_we, state}, {28'd0, 1'b1, 3'd3});
        tick();
        drv(1, OP_ST, 2, 0, 0, 0);
        @(negedge clk);
        chk("sw_rst_we", {30'd0, mem_we, mem_req}, 32'd0);
        tick();
        drv(0, OP_ST, 2, 0, 0, 0);
        @(negedge clk);
        chk("sw_rst_next", {27'd0, mem_we, mem_req, state}, {27'd0, 1'b0, 1'b1, 3'd0});
`ifdef CTRL_PERF_CNT_EN
        chk("perf_rst_cycle", cycle_cnt, 32'd0);
        chk("perf_rst_instret", instret_cnt, 32'd0);
        drv(0, OP_I, 0, 1, 0, 1);
        tick(); tick(); tick(); tick();
        chk("perf_addi_cycle", cycle_cnt, 32'd4);
        chk("perf_addi_instret", instret_cnt, 32'd1);
        drv(0, OP_BAD, 0, 0, 0, 1);
        tick(); tick();
        for (int k = 0; k < 5; k++) tick();
        chk("perf_trap_cycle", cycle_cnt, 32'd6);
        chk("perf_trap_instret", instret_cnt, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
